// File: rtl/arm_pkg.sv
// arm_pkg: micro-op codes, ARM opcode/condition constants, field positions and decode record.
package arm_pkg;
    typedef enum logic [4:0] {
        UOP_NOP = 5'd0,
        UOP_ADD = 5'd1,
        UOP_SUB = 5'd2,
        UOP_AND = 5'd3,
        UOP_ORR = 5'd4,
        UOP_CMP = 5'd5,
        UOP_EOR = 5'd6,
        UOP_MVN = 5'd7,
        UOP_MOV = 5'd8,
        UOP_B   = 5'd9
    } uop_t;
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_MVN = 4'hF;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;
    localparam int COND_LSB = 28;
    localparam int I_BIT    = 25;
    localparam int L_BIT    = 24;
    localparam int OPC_LSB  = 21;
    localparam int S_BIT    = 20;
    localparam int RN_LSB   = 16;
    localparam int RD_LSB   = 12;
    localparam int ROT_LSB  = 8;
    typedef struct packed {
        uop_t        uop;
        logic [31:0] num;
        logic        num_to_rhs;
        logic [3:0]  sel_p0;
        logic [3:0]  sel_p1;
        logic [3:0]  sel_in;
        logic [3:0]  branch_cond;
    } dec_t;
    function automatic logic [31:0] rot_imm(input logic [7:0] imm, input logic [3:0] rot);
        logic [63:0] t;
        t = {24'h0, imm, 24'h0, imm} >> {rot, 1'b0};
        return t[31:0];
    endfunction
endpackage

// File: rtl/fetch_decode_if.sv
// fetch_decode_if: instruction-memory port, execute feedback and decoded operand outputs.
interface fetch_decode_if;
    import arm_pkg::*;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        global_disable;
    logic [31:0] delta_instruction;
    logic        num_to_rhs;
    logic [31:0] num;
    logic [3:0]  sel_p0;
    logic [3:0]  sel_p1;
    logic [3:0]  sel_in;
    uop_t        uop;
    logic [3:0]  branch_cond;
    logic        undef;
    modport master (
        output imem_addr, num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond, undef,
        input  imem_data, global_disable, delta_instruction
    );
    modport slave (
        input  imem_addr, num_to_rhs, num, sel_p0, sel_p1, sel_in, uop, branch_cond, undef,
        output imem_data, global_disable, delta_instruction
    );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: combinational ARM subset decode (AL data-processing and B) to micro-op fields.
module instr_decoder
    import arm_pkg::*;
(
    input  logic [31:0] word,
    output dec_t        dec,
    output logic        undef
);
    logic [3:0] cond, opc, rn, rd, rm;
    logic       imm, dp, br, single;
    uop_t       dp_uop;
    assign cond   = word[COND_LSB+:4];
    assign opc    = word[OPC_LSB+:4];
    assign rn     = word[RN_LSB+:4];
    assign rd     = word[RD_LSB+:4];
    assign rm     = word[3:0];
    assign imm    = word[I_BIT];
    // Register operands only without any shift; bits 11:4 also cover multiply/misc space.
    assign dp     = word[27:26] == 2'b00 && cond == COND_AL && (imm || word[11:4] == 8'h0);
    assign br     = word[27:25] == 3'b101 && !word[L_BIT] && cond != COND_NV;
    assign single = dp_uop == UOP_MOV || dp_uop == UOP_MVN;
    always_comb begin
        dp_uop = UOP_NOP;
        case (opc)
            OP_AND:  dp_uop = UOP_AND;
            OP_EOR:  dp_uop = UOP_EOR;
            OP_SUB:  dp_uop = UOP_SUB;
            OP_ADD:  dp_uop = UOP_ADD;
            OP_CMP:  dp_uop = word[S_BIT] ? UOP_CMP : UOP_NOP;
            OP_ORR:  dp_uop = UOP_ORR;
            OP_MOV:  dp_uop = UOP_MOV;
            OP_MVN:  dp_uop = UOP_MVN;
            default: dp_uop = UOP_NOP;
        endcase
    end
    always_comb begin
        dec   = '0;
        undef = 1'b0;
        if (br) begin
            dec.uop         = UOP_B;
            dec.branch_cond = cond;
            dec.num         = {{8{word[23]}}, word[23:0]};
            dec.num_to_rhs  = 1'b1;
        end else if (dp && dp_uop != UOP_NOP) begin
            dec.uop        = dp_uop;
            dec.num_to_rhs = imm;
            dec.num        = imm ? rot_imm(word[7:0], word[ROT_LSB+:4]) : 32'h0;
            dec.sel_p0     = single ? (imm ? 4'h0 : rm) : rn;
            dec.sel_p1     = (imm || single) ? 4'h0 : rm;
            dec.sel_in     = dp_uop == UOP_CMP ? 4'h0 : rd;
        end else begin
            undef = 1'b1;
        end
    end
endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: pc generation, fetch register, registered decode and branch flush control.
module fetch_decode
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           clk,
    input  logic           reset,
    fetch_decode_if.master bus
);
    logic [31:0] pc, f_pc, ex_pc;
    logic        f_valid, dec_undef, undef_q;
    dec_t        dec, dec_q;
    instr_decoder u_dec (
        .word  (bus.imem_data),
        .dec   (dec),
        .undef (dec_undef)
    );
    // A redirect kills the word in decode now and the one in flight in memory next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            f_pc    <= 32'h0;
            f_valid <= 1'b0;
            ex_pc   <= 32'h0;
            dec_q   <= '0;
            undef_q <= 1'b0;
        end else begin
            pc      <= bus.global_disable ? ex_pc + bus.delta_instruction : pc + 32'h1;
            f_pc    <= pc;
            f_valid <= !bus.global_disable;
            ex_pc   <= f_pc;
            dec_q   <= (bus.global_disable || !f_valid) ? '0 : dec;
            undef_q <= !bus.global_disable && f_valid && dec_undef;
        end
    end
    assign bus.imem_addr   = pc;
    assign bus.uop         = dec_q.uop;
    assign bus.num         = dec_q.num;
    assign bus.num_to_rhs  = dec_q.num_to_rhs;
    assign bus.sel_p0      = dec_q.sel_p0;
    assign bus.sel_p1      = dec_q.sel_p1;
    assign bus.sel_in      = dec_q.sel_in;
    assign bus.branch_cond = dec_q.branch_cond;
    assign bus.undef       = undef_q;
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: table-driven decode vectors plus flush, wrap and reset sequences with a scoreboard.
module tb_fetch_decode;
    import arm_pkg::*;
    typedef struct packed {
        logic [4:0]  uop;
        logic [31:0] num;
        logic        rhs;
        logic [3:0]  p0;
        logic [3:0]  p1;
        logic [3:0]  in;
        logic [3:0]  cond;
        logic        undef;
    } exp_t;
    typedef struct {
        logic [31:0] word;
        exp_t        e;
    } vec_t;
    localparam exp_t NOP = '0;
    localparam exp_t BAD = 55'h1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] mem [64];
    exp_t q [$];
    vec_t vecs [19];
    int checks = 0;
    int fails = 0;
    always #5 clk = ~clk;
    fetch_decode_if bus ();
    fetch_decode #(.RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
    always @(posedge clk) bus.imem_data <= mem[bus.imem_addr[5:0]];
    function automatic exp_t ex(input logic [4:0] u, input logic [31:0] n, input logic r,
                                input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] in,
                                input logic [3:0] c);
        return {u, n, r, p0, p1, in, c, 1'b0};
    endfunction
    function automatic logic [31:0] mov_w(input int k);
        return {16'hE3A0, 4'(k), 4'h0, 8'(k)};
    endfunction
    function automatic exp_t mov_e(input int k);
        return ex(5'd8, {24'h0, 8'(k)}, 1'b1, 4'h0, 4'h0, 4'(k), 4'h0);
    endfunction
    task automatic tick(input exp_t e, input logic [31:0] addr);
        exp_t a, w;
        q.push_back(e);
        @(posedge clk);
        #1;
        w = q.pop_front();
        a = {bus.uop, bus.num, bus.num_to_rhs, bus.sel_p0, bus.sel_p1, bus.sel_in, bus.branch_cond, bus.undef};
        checks++;
        if (a !== w) begin
            fails++;
            $display("FAIL decode @%0t: got uop=%0d num=%h rhs=%b p0=%0d p1=%0d in=%0d cond=%h undef=%b, expected uop=%0d num=%h rhs=%b p0=%0d p1=%0d in=%0d cond=%h undef=%b",
                     $time, a.uop, a.num, a.rhs, a.p0, a.p1, a.in, a.cond, a.undef,
                     w.uop, w.num, w.rhs, w.p0, w.p1, w.in, w.cond, w.undef);
        end
        checks++;
        if (bus.imem_addr !== addr) begin
            fails++;
            $display("FAIL imem_addr @%0t: got %h expected %h", $time, bus.imem_addr, addr);
        end
    endtask
    initial begin
        vecs[0]  = '{32'hE3A01CFE, ex(5'd8, 32'h0000FE00, 1'b1, 4'd0, 4'd0, 4'd1, 4'h0)};
        vecs[1]  = '{32'hE0813002, ex(5'd1, 32'h0, 1'b0, 4'd1, 4'd2, 4'd3, 4'h0)};
        vecs[2]  = '{32'hE1520003, ex(5'd5, 32'h0, 1'b0, 4'd2, 4'd3, 4'd0, 4'h0)};
        vecs[3]  = '{32'h0A000004, ex(5'd9, 32'h4, 1'b1, 4'd0, 4'd0, 4'd0, 4'h0)};
        vecs[4]  = '{32'hFFFFFFFF, BAD};
        vecs[5]  = '{32'hE0813102, BAD};
        vecs[6]  = '{32'hE1A05004, ex(5'd8, 32'h0, 1'b0, 4'd4, 4'd0, 4'd5, 4'h0)};
        vecs[7]  = '{32'hE2423001, ex(5'd2, 32'h1, 1'b1, 4'd2, 4'd0, 4'd3, 4'h0)};
        vecs[8]  = '{32'hE20101FF, ex(5'd3, 32'hC000003F, 1'b1, 4'd1, 4'd0, 4'd0, 4'h0)};
        vecs[9]  = '{32'hE1887009, ex(5'd4, 32'h0, 1'b0, 4'd8, 4'd9, 4'd7, 4'h0)};
        vecs[10] = '{32'hE0321003, ex(5'd6, 32'h0, 1'b0, 4'd2, 4'd3, 4'd1, 4'h0)};
        vecs[11] = '{32'hE3E02055, ex(5'd7, 32'h55, 1'b1, 4'd0, 4'd0, 4'd2, 4'h0)};
        vecs[12] = '{32'hEAFFFFFE, ex(5'd9, 32'hFFFFFFFE, 1'b1, 4'd0, 4'd0, 4'd0, 4'hE)};
        vecs[13] = '{32'hEB000000, BAD};
        vecs[14] = '{32'h10813002, BAD};
        vecs[15] = '{32'hFA000000, BAD};
        vecs[16] = '{32'hE1120003, BAD};
        vecs[17] = '{32'hE0813012, BAD};
        vecs[18] = '{32'hE3A0F0AB, ex(5'd8, 32'hAB, 1'b1, 4'd0, 4'd0, 4'd15, 4'h0)};
        bus.global_disable = 1'b0;
        bus.delta_instruction = 32'h0;
        for (int k = 0; k < 64; k++) mem[k] = mov_w(k);
        for (int i = 0; i < 19; i++) mem[i] = vecs[i].word;
        tick(NOP, 32'h0);
        tick(NOP, 32'h0);
        reset = 1'b0;
        tick(NOP, 32'h1);
        for (int i = 0; i < 19; i++) tick(vecs[i].e, 32'(i + 2));
        // Branch at index 5 redirects back to index 3; the two slots after it must stay silent NOPs.
        for (int k = 0; k < 64; k++) mem[k] = mov_w(k);
        mem[5] = 32'h0A000004;
        mem[6] = 32'hFFFFFFFF;
        mem[7] = 32'hFFFFFFFF;
        reset = 1'b1;
        tick(NOP, 32'h0);
        reset = 1'b0;
        tick(NOP, 32'h1);
        for (int k = 2; k <= 7; k++) tick((k == 7) ? vecs[3].e : mov_e(k - 2), 32'(k));
        bus.global_disable = 1'b1;
        bus.delta_instruction = 32'hFFFFFFFE;
        tick(NOP, 32'h3);
        bus.global_disable = 1'b0;
        tick(NOP, 32'h4);
        tick(mov_e(3), 32'h5);
        bus.global_disable = 1'b1;
        bus.delta_instruction = 32'd10;
        tick(NOP, 32'd13);
        bus.delta_instruction = 32'd20;
        tick(NOP, 32'd24);
        bus.global_disable = 1'b0;
        tick(NOP, 32'd25);
        tick(mov_e(24), 32'd26);
        // Redirect to the last index, then wrap to zero; finally reset during a redirect.
        reset = 1'b1;
        tick(NOP, 32'h0);
        reset = 1'b0;
        bus.global_disable = 1'b1;
        bus.delta_instruction = 32'hFFFFFFFF;
        tick(NOP, 32'hFFFFFFFF);
        bus.global_disable = 1'b0;
        tick(NOP, 32'h0);
        tick(mov_e(63), 32'h1);
        tick(mov_e(0), 32'h2);
        reset = 1'b1;
        bus.global_disable = 1'b1;
        bus.delta_instruction = 32'd100;
        tick(NOP, 32'h0);
        reset = 1'b0;
        bus.global_disable = 1'b0;
        tick(NOP, 32'h1);
        tick(mov_e(0), 32'h2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
